// File: rtl/week04_fourth.sv
// -----------------------------------------------------------------------------
// week04_fourth
//
// A clock-enabled data-holding register with load bookkeeping. It sits between
// a producer that drives Din/Ce and downstream logic that samples the
// registered Dout. The status outputs tell the consumer two things:
//   * whether any data has been captured since reset, and
//   * how many loads have happened since reset.
//
// Optional feature: define WEEK04_FOURTH_PARITY_EN to add the Dpar output,
// which is the XOR of all Dout bits.
//
// Parameters
//   WIDTH  data width of Din/Dout (>= 1), default 4
//   CNT_W  width of the load counter Lcnt (>= 1), default 8
//
// Ports
//   CLK   in   1      sole clock, rising-edge active
//   RST   in   1      asynchronous, active-low reset
//   Ce    in   1      load enable, sampled at the rising edge
//   Din   in   WIDTH  data to capture
//   Dout  out  WIDTH  registered data
//   Dvld  out  1      high once at least one load has occurred since reset
//   Lcnt  out  CNT_W  loads since reset, saturates at all-ones
//   Dchg  out  1      one-cycle pulse: the last edge loaded a value that
//                     differs from the previous Dout
//   Dpar  out  1      XOR of Dout bits (only with WEEK04_FOURTH_PARITY_EN)
//
// Every output comes straight from a register, or from combinational logic
// fed only by the Dout register. There is no path from Din or Ce to any
// output within the same cycle.
// -----------------------------------------------------------------------------
module week04_fourth #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Ce,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             Dvld,
    output logic [CNT_W-1:0] Lcnt,
    output logic             Dchg
`ifdef WEEK04_FOURTH_PARITY_EN
    ,
    output logic             Dpar
`endif
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] dout_reg;
    logic [WIDTH-1:0] dout_next;
    logic             dvld_reg;
    logic             dvld_next;
    logic [CNT_W-1:0] lcnt_reg;
    logic [CNT_W-1:0] lcnt_next;
    logic             dchg_reg;
    logic             dchg_next;

    // -------------------------------------------------------------------------
    // Change detection: compare the incoming word with the currently held word
    // bit by bit, then OR-reduce the result. The comparison is only acted upon
    // when Ce is high.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] bit_diff;
    logic             data_differs;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_diff
            assign bit_diff[gi] = Din[gi] ^ dout_reg[gi];
        end
    endgenerate

    assign data_differs = |bit_diff;

    // Once the counter is all-ones, it holds that value instead of wrapping.
    logic lcnt_full;
    assign lcnt_full = &lcnt_reg;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        dout_next = dout_reg;
        dvld_next = dvld_reg;
        lcnt_next = lcnt_reg;
        dchg_next = 1'b0;           // pulse: cleared on every non-loading edge

        if (Ce) begin
            dout_next = Din;
            dvld_next = 1'b1;
            // An equal-value load still counts as a load; it just does not
            // raise Dchg.
            dchg_next = data_differs;
            if (!lcnt_full) begin
                lcnt_next = lcnt_reg + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset clears everything at once, without waiting for a
    // clock edge, so all load history is lost and the counter restarts from 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dout_reg <= '0;
            dvld_reg <= 1'b0;
            lcnt_reg <= '0;
            dchg_reg <= 1'b0;
        end else begin
            dout_reg <= dout_next;
            dvld_reg <= dvld_next;
            lcnt_reg <= lcnt_next;
            dchg_reg <= dchg_next;
        end
    end

    assign Dout = dout_reg;
    assign Dvld = dvld_reg;
    assign Lcnt = lcnt_reg;
    assign Dchg = dchg_reg;

`ifdef WEEK04_FOURTH_PARITY_EN
    // -------------------------------------------------------------------------
    // Parity is a pure function of the held word. It is built as an XOR chain
    // over the Dout register and adds no extra state. Because Dout resets to 0,
    // Dpar also reads 0 during reset.
    // -------------------------------------------------------------------------
    logic [WIDTH:0] par_chain;

    assign par_chain[0] = 1'b0;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ dout_reg[gi];
        end
    endgenerate

    assign Dpar = par_chain[WIDTH];
`endif

endmodule

// File: tb/tb_week04_fourth.sv
// -----------------------------------------------------------------------------
// tb_week04_fourth
//
// Self-checking bench for week04_fourth.
//   * u_dut: default parameters (WIDTH=4, CNT_W=8).
//   * u_sat: CNT_W=2, used to exercise counter saturation.
//
// Most of the stimulus comes from a vector table of inputs and expected
// outputs. Each vector's expectation is pushed to a queue when the vector is
// driven, then popped and compared after the clock edge has been applied.
// Hand-written sequences cover:
//   * reset behaviour,
//   * input glitches between edges,
//   * asynchronous reset in the middle of a run,
//   * counter saturation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_week04_fourth;

    logic       clk;
    logic       rst;
    logic       ce;
    logic [3:0] din;
    logic [3:0] dout;
    logic       dvld;
    logic [7:0] lcnt;
    logic       dchg;

    logic       ce_s;
    logic [3:0] din_s;
    logic [3:0] dout_s;
    logic       dvld_s;
    logic [1:0] lcnt_s;
    logic       dchg_s;

`ifdef WEEK04_FOURTH_PARITY_EN
    logic       dpar;
    logic       dpar_s;
`endif

    week04_fourth #(.WIDTH(4), .CNT_W(8)) u_dut (
        .CLK  (clk),
        .RST  (rst),
        .Ce   (ce),
        .Din  (din),
        .Dout (dout),
        .Dvld (dvld),
        .Lcnt (lcnt),
        .Dchg (dchg)
`ifdef WEEK04_FOURTH_PARITY_EN
        ,
        .Dpar (dpar)
`endif
    );

    week04_fourth #(.WIDTH(4), .CNT_W(2)) u_sat (
        .CLK  (clk),
        .RST  (rst),
        .Ce   (ce_s),
        .Din  (din_s),
        .Dout (dout_s),
        .Dvld (dvld_s),
        .Lcnt (lcnt_s),
        .Dchg (dchg_s)
`ifdef WEEK04_FOURTH_PARITY_EN
        ,
        .Dpar (dpar_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit, so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       ce;
        logic [3:0] din;
        logic [3:0] dout;
        logic       dvld;
        logic [7:0] lcnt;
        logic       dchg;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] dout;
        logic       dvld;
        logic [7:0] lcnt;
        logic       dchg;
    } exp_t;

    exp_t sb[$];

    int n_vec;
    int n_err;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_main(input string name, input logic [3:0] e_dout,
                              input logic e_dvld, input logic [7:0] e_lcnt,
                              input logic e_dchg);
        check({name, ".Dout"}, int'(dout), int'(e_dout));
        check({name, ".Dvld"}, int'(dvld), int'(e_dvld));
        check({name, ".Lcnt"}, int'(lcnt), int'(e_lcnt));
        check({name, ".Dchg"}, int'(dchg), int'(e_dchg));
`ifdef WEEK04_FOURTH_PARITY_EN
        check({name, ".Dpar"}, int'(dpar), int'(^e_dout));
`endif
        $display("%s: Dout=%h Dvld=%0d Lcnt=%0d Dchg=%0d", name, dout, dvld, lcnt, dchg);
    endtask

    // Called at a negedge: drive the vector, record its expectation, step one
    // clock, then pop the expectation and compare it with the DUT outputs.
    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        ce  = v.ce;
        din = v.din;
        sb.push_back('{name, v.dout, v.dvld, v.lcnt, v.dchg});
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check_main(e.name, e.dout, e.dvld, e.lcnt, e.dchg);
        end
    endtask

    vec_t tbl[12];
    vec_t ld[4];
    int   sat_exp[5];

    initial begin
        n_vec = 0;
        n_err = 0;

        // Fields: ce, din, exp dout, exp dvld, exp lcnt, exp dchg.
        tbl[0]  = '{1'b0, 4'h1, 4'h0, 1'b0, 8'd0, 1'b0};  // hold after reset
        tbl[1]  = '{1'b0, 4'h1, 4'h0, 1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b1, 4'h1, 4'h1, 1'b1, 8'd1, 1'b1};  // load sequence
        tbl[3]  = '{1'b1, 4'h2, 4'h2, 1'b1, 8'd2, 1'b1};
        tbl[4]  = '{1'b1, 4'h4, 4'h4, 1'b1, 8'd3, 1'b1};
        tbl[5]  = '{1'b1, 4'h8, 4'h8, 1'b1, 8'd4, 1'b1};
        tbl[6]  = '{1'b0, 4'h3, 4'h8, 1'b1, 8'd4, 1'b0};  // alternating enable
        tbl[7]  = '{1'b1, 4'h5, 4'h5, 1'b1, 8'd5, 1'b1};
        tbl[8]  = '{1'b0, 4'h6, 4'h5, 1'b1, 8'd5, 1'b0};
        tbl[9]  = '{1'b1, 4'h5, 4'h5, 1'b1, 8'd6, 1'b0};  // equal-value load
        tbl[10] = '{1'b1, 4'h9, 4'h9, 1'b1, 8'd7, 1'b1};
        tbl[11] = '{1'b0, 4'h9, 4'h9, 1'b1, 8'd7, 1'b0};

        ld[0] = '{1'b1, 4'h1, 4'h1, 1'b1, 8'd1, 1'b1};
        ld[1] = '{1'b1, 4'h2, 4'h2, 1'b1, 8'd2, 1'b1};
        ld[2] = '{1'b1, 4'h4, 4'h4, 1'b1, 8'd3, 1'b1};
        ld[3] = '{1'b1, 4'h8, 4'h8, 1'b1, 8'd4, 1'b1};

        sat_exp = '{1, 2, 3, 3, 3};

        // Reset held low with the enable active and the clock running.
        rst   = 1'b0;
        ce    = 1'b1;
        din   = 4'hF;
        ce_s  = 1'b0;
        din_s = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_main($sformatf("reset_hold%0d", i), 4'h0, 1'b0, 8'd0, 1'b0);
        end

        // Release reset away from the active edge, then run the vector table.
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Ce/Din glitch between edges: only the levels at the edge count.
        ce  = 1'b0;
        din = 4'h7;
        #2;
        ce  = 1'b1;
        din = 4'hA;
        #2;
        ce  = 1'b0;
        din = 4'h7;
        @(posedge clk);
        @(negedge clk);
        check_main("glitch", 4'h9, 1'b1, 8'd7, 1'b0);

        // Start from a fresh reset, then load up to Dout=8 and Lcnt=4.
        rst = 1'b0;
        #1;
        check_main("rst_pulse", 4'h0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("reload%0d", i), ld[i]);
        end

        // Assert reset between edges: the outputs must clear before any edge.
        ce  = 1'b1;
        din = 4'hF;
        #2;
        rst = 1'b0;
        #1;
        check_main("async_rst", 4'h0, 1'b0, 8'd0, 1'b0);

        // Activity while reset is held low must be ignored.
        @(posedge clk);
        @(negedge clk);
        check_main("rst_ignore", 4'h0, 1'b0, 8'd0, 1'b0);

        // Release reset: the first load restarts the counter at 1.
        rst = 1'b1;
        run_vec("post_rst_load", '{1'b1, 4'h3, 4'h3, 1'b1, 8'd1, 1'b1});

        // Saturation of the 2-bit counter over five loads.
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ce_s  = 1'b1;
            din_s = 4'(i + 1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("sat%0d.Lcnt", i), int'(lcnt_s), sat_exp[i]);
            check($sformatf("sat%0d.Dout", i), int'(dout_s), i + 1);
            $display("sat%0d: Lcnt=%0d Dout=%h", i, lcnt_s, dout_s);
        end
        ce_s = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
